// File: rtl/bnn_conv_pkg.sv
// Shared types and defaults for the binary convolution engine.
// State encoding, default widths and the majority threshold helper.
package bnn_conv_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 12;
    localparam int KMAX_DEF   = 5;

    localparam logic [15:0] END_MARKER_DEF = 16'h00FF;

    typedef enum logic [2:0] {
        IDLE,
        W_DIM,
        W_DATA,
        M_HDR,
        FILL,
        COMPUTE,
        WRITE,
        DONE
    } state_t;

    function automatic int majority_thresh(input int k);
        return (k * k - 1) / 2;
    endfunction

endpackage

// File: rtl/bnn_row_majority.sv
// Combinational row evaluator: per-column XOR of window vs kernel,
// popcount of disagreements, and strict-majority decision.
module bnn_row_majority
    import bnn_conv_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int KMAX   = KMAX_DEF,
    parameter int KW     = $clog2(KMAX + 1)
) (
    input  logic [KMAX*DATA_W-1:0] lbuf,
    input  logic [2*DATA_W-1:0]    kern,
    input  logic [KW-1:0]          k,
    input  logic [DATA_W-1:0]      ncols,
    output logic [DATA_W-1:0]      row
);

    genvar c;
    generate
        for (c = 0; c < DATA_W; c++) begin : g_col
            logic bit_c;

            // Count sign disagreements in the window anchored at column c
            always_comb begin
                int neg;
                int kk;
                neg = 0;
                kk  = int'(k);
                for (int r = 0; r < KMAX; r++) begin
                    for (int j = 0; j < KMAX; j++) begin
                        if (r < kk && j < kk && c + j < DATA_W) begin
                            neg = neg + int'(
                                1'(kern >> (r * kk + j)) ^
                                1'(lbuf >> (r * DATA_W + c + j)));
                        end
                    end
                end
                bit_c = (c + kk <= int'(ncols)) &&
                        (neg <= majority_thresh(kk));
            end

            assign row[c] = bit_c;
        end
    endgenerate

endmodule

// File: rtl/bnn_conv_engine.sv
// Runtime-K binary convolution engine: fetches kernel, streams matrices,
// writes a header plus one packed majority row per output row.
module bnn_conv_engine
    import bnn_conv_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int KMAX   = KMAX_DEF,
    parameter logic [DATA_W-1:0] END_MARKER = DATA_W'(END_MARKER_DEF)
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              dut_run,
    output logic              dut_busy,
    output logic              dut_error,
    output logic [ADDR_W-1:0] dut_wmem_read_address,
    input  logic [DATA_W-1:0] wmem_dut_read_data,
    output logic [ADDR_W-1:0] dut_sram_read_address,
    input  logic [DATA_W-1:0] sram_dut_read_data,
    output logic [ADDR_W-1:0] dut_sram_write_address,
    output logic [DATA_W-1:0] dut_sram_write_data,
    output logic              dut_sram_write_enable
);

    localparam int KW   = $clog2(KMAX + 1);
    localparam int LB_W = KMAX * DATA_W;

    localparam logic [DATA_W-1:0] ONE_D  = DATA_W'(1);
    localparam logic [ADDR_W-1:0] ONE_A  = ADDR_W'(1);
    localparam logic [DATA_W-1:0] KMAX_D = DATA_W'(KMAX);
    localparam logic [DATA_W-1:0] MAXC_D = DATA_W'(DATA_W);
    localparam logic [LB_W-1:0]   ROW_MASK = LB_W'({DATA_W{1'b1}});

    state_t              state, nxt_state;
    logic [2:0]          step, nxt_step;
    logic [KW-1:0]       k, nxt_k;
    logic [2*DATA_W-1:0] kern, nxt_kern;
    logic [LB_W-1:0]     lbuf, nxt_lbuf;
    logic [DATA_W-1:0]   nrows, nxt_nrows;
    logic [DATA_W-1:0]   ncols, nxt_ncols;
    logic [DATA_W-1:0]   row_cnt, nxt_row_cnt;
    logic [DATA_W-1:0]   out_row, nxt_out_row;
    logic [ADDR_W-1:0]   w_addr, nxt_w_addr;
    logic [ADDR_W-1:0]   r_addr, nxt_r_addr;
    logic [ADDR_W-1:0]   wr_ptr, nxt_wr_ptr;
    logic [ADDR_W-1:0]   wr_addr, nxt_wr_addr;
    logic [DATA_W-1:0]   wr_data, nxt_wr_data;
    logic                wr_en, nxt_wr_en;
    logic                busy, nxt_busy;
    logic                err, nxt_err;

    logic [DATA_W-1:0]   maj_row;
    logic [DATA_W-1:0]   k_d;
    logic [LB_W-1:0]     lbuf_in;
    int                  ins_sh;

    assign k_d    = DATA_W'(k);
    assign ins_sh = (int'(k) - 1) * DATA_W;

    // Drop the oldest row and place the incoming row at kernel row K-1
    assign lbuf_in = ((lbuf >> DATA_W) & ~(ROW_MASK << ins_sh)) |
                     (LB_W'(sram_dut_read_data) << ins_sh);

    bnn_row_majority #(
        .DATA_W (DATA_W),
        .KMAX   (KMAX),
        .KW     (KW)
    ) u_row_majority (
        .lbuf   (lbuf),
        .kern   (kern),
        .k      (k),
        .ncols  (ncols),
        .row    (maj_row)
    );

    // State and datapath registers; async reset aborts to IDLE with zeros
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state   <= IDLE;
            step    <= '0;
            k       <= '0;
            kern    <= '0;
            lbuf    <= '0;
            nrows   <= '0;
            ncols   <= '0;
            row_cnt <= '0;
            out_row <= '0;
            w_addr  <= '0;
            r_addr  <= '0;
            wr_ptr  <= '0;
            wr_addr <= '0;
            wr_data <= '0;
            wr_en   <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= nxt_state;
            step    <= nxt_step;
            k       <= nxt_k;
            kern    <= nxt_kern;
            lbuf    <= nxt_lbuf;
            nrows   <= nxt_nrows;
            ncols   <= nxt_ncols;
            row_cnt <= nxt_row_cnt;
            out_row <= nxt_out_row;
            w_addr  <= nxt_w_addr;
            r_addr  <= nxt_r_addr;
            wr_ptr  <= nxt_wr_ptr;
            wr_addr <= nxt_wr_addr;
            wr_data <= nxt_wr_data;
            wr_en   <= nxt_wr_en;
            busy    <= nxt_busy;
            err     <= nxt_err;
        end
    end

    // Next-state and datapath updates; reads wait one step for data
    always_comb begin
        nxt_state   = state;
        nxt_step    = step;
        nxt_k       = k;
        nxt_kern    = kern;
        nxt_lbuf    = lbuf;
        nxt_nrows   = nrows;
        nxt_ncols   = ncols;
        nxt_row_cnt = row_cnt;
        nxt_out_row = out_row;
        nxt_w_addr  = w_addr;
        nxt_r_addr  = r_addr;
        nxt_wr_ptr  = wr_ptr;
        nxt_wr_addr = wr_addr;
        nxt_wr_data = wr_data;
        nxt_wr_en   = 1'b0;
        nxt_busy    = busy;
        nxt_err     = err;

        unique case (state)
            IDLE: begin
                if (dut_run) begin
                    nxt_state  = W_DIM;
                    nxt_step   = '0;
                    nxt_busy   = 1'b1;
                    nxt_err    = 1'b0;
                    nxt_w_addr = '0;
                    nxt_r_addr = '0;
                    nxt_wr_ptr = '0;
                end
            end
            W_DIM: begin
                if (step == 3'd0) begin
                    nxt_step = 3'd1;
                end else if (wmem_dut_read_data == '0 ||
                             !wmem_dut_read_data[0] ||
                             wmem_dut_read_data > KMAX_D) begin
                    nxt_err   = 1'b1;
                    nxt_state = DONE;
                end else begin
                    nxt_k      = KW'(wmem_dut_read_data);
                    nxt_w_addr = ONE_A;
                    nxt_step   = '0;
                    nxt_state  = W_DATA;
                end
            end
            W_DATA: begin
                if (step == 3'd0) begin
                    nxt_step = 3'd1;
                end else if (w_addr == ONE_A) begin
                    nxt_kern[DATA_W-1:0] = wmem_dut_read_data;
                    nxt_step = '0;
                    if (int'(k) * int'(k) > DATA_W) begin
                        nxt_w_addr = w_addr + ONE_A;
                    end else begin
                        nxt_state = M_HDR;
                    end
                end else begin
                    nxt_kern[2*DATA_W-1:DATA_W] = wmem_dut_read_data;
                    nxt_step  = '0;
                    nxt_state = M_HDR;
                end
            end
            M_HDR: begin
                case (step)
                    3'd1: begin
                        nxt_nrows = sram_dut_read_data;
                        if (sram_dut_read_data == END_MARKER) begin
                            nxt_state = DONE;
                        end else begin
                            nxt_r_addr = r_addr + ONE_A;
                            nxt_step   = 3'd2;
                        end
                    end
                    3'd3: begin
                        nxt_ncols = sram_dut_read_data;
                        if (nrows < k_d ||
                            sram_dut_read_data < k_d ||
                            sram_dut_read_data > MAXC_D) begin
                            nxt_err   = 1'b1;
                            nxt_state = DONE;
                        end else begin
                            nxt_wr_en   = 1'b1;
                            nxt_wr_addr = wr_ptr;
                            nxt_wr_data = nrows - k_d + ONE_D;
                            nxt_wr_ptr  = wr_ptr + ONE_A;
                            nxt_step    = 3'd4;
                        end
                    end
                    3'd4: begin
                        nxt_wr_en   = 1'b1;
                        nxt_wr_addr = wr_ptr;
                        nxt_wr_data = ncols - k_d + ONE_D;
                        nxt_wr_ptr  = wr_ptr + ONE_A;
                        nxt_r_addr  = r_addr + ONE_A;
                        nxt_row_cnt = '0;
                        nxt_step    = '0;
                        nxt_state   = FILL;
                    end
                    default: begin
                        nxt_step = step + 3'd1;
                    end
                endcase
            end
            FILL: begin
                if (step == 3'd0) begin
                    nxt_step = 3'd1;
                end else begin
                    nxt_lbuf    = lbuf_in;
                    nxt_row_cnt = row_cnt + ONE_D;
                    nxt_r_addr  = r_addr + ONE_A;
                    nxt_step    = '0;
                    if (row_cnt + ONE_D == k_d) begin
                        nxt_state = COMPUTE;
                    end
                end
            end
            COMPUTE: begin
                nxt_out_row = maj_row;
                nxt_state   = WRITE;
            end
            WRITE: begin
                nxt_wr_en   = 1'b1;
                nxt_wr_addr = wr_ptr;
                nxt_wr_data = out_row;
                nxt_wr_ptr  = wr_ptr + ONE_A;
                if (row_cnt < nrows) begin
                    nxt_lbuf    = lbuf_in;
                    nxt_row_cnt = row_cnt + ONE_D;
                    nxt_r_addr  = r_addr + ONE_A;
                    nxt_state   = COMPUTE;
                end else begin
                    nxt_step  = '0;
                    nxt_state = M_HDR;
                end
            end
            DONE: begin
                nxt_busy  = 1'b0;
                nxt_state = IDLE;
            end
        endcase
    end

    assign dut_busy               = busy;
    assign dut_error              = err;
    assign dut_wmem_read_address  = w_addr;
    assign dut_sram_read_address  = r_addr;
    assign dut_sram_write_address = wr_addr;
    assign dut_sram_write_data    = wr_data;
    assign dut_sram_write_enable  = wr_en;

endmodule

// File: doc/bnn_conv_engine.md
Name: bnn_conv_engine

Overview:
- Parametrised successor to the fixed 3x3 binary convolution datapath.
- Streams packed binary matrices from input SRAM and convolves each with a runtime-sized odd KxK binary kernel (K <= KMAX) read from weight memory.
- Writes one packed output word per output row to output SRAM.
- Adds two things the fixed design lacks: runtime kernel size, and an error status for illegal dimensions. Sits directly under the top-level DUT interface.

Parameters:
- DATA_W, 16, SRAM word width and maximum matrix column count.
- ADDR_W, 12, SRAM address width.
- KMAX, 5, largest legal kernel dimension; must be odd, 3 or 5.
- END_MARKER, 16'h00FF, word in the nrows slot that terminates the run.

Ports:
- clk  in  1  clock.
- reset_b  in  1  asynchronous active-low reset.
- dut_run  in  1  start pulse, sampled only in IDLE.
- dut_busy  out  1  high from start until the last write retires.
- dut_error  out  1  sticky illegal-dimension flag; cleared on next start.
- dut_wmem_read_address  out  ADDR_W  weight memory address.
- wmem_dut_read_data  in  DATA_W  weight data, valid 1 cycle after address.
- dut_sram_read_address  out  ADDR_W  input SRAM address.
- sram_dut_read_data  in  DATA_W  input data, valid 1 cycle after address.
- dut_sram_write_address  out  ADDR_W  output SRAM address.
- dut_sram_write_data  out  DATA_W  output word.
- dut_sram_write_enable  out  1  one-cycle write strobe.

Behaviour:
- Reset: all outputs, addresses, line buffer and state are 0; state is IDLE.
- Encoding: bit 1 = +1, bit 0 = -1. A product is negative iff the weight and pixel bits differ. The output bit is 1 iff negatives <= (K*K-1)/2 (strict majority; no tie because K is odd).
- Weight memory layout:
  - word0 = K.
  - Kernel bit index r*K+c, row-major.
  - Bits 0-15 in word1; bits 16-24 in word2 (word2 read only when K*K > 16).
- Input SRAM layout, per matrix: nrows, ncols, then nrows row words, with column c at bit c. Matrices are contiguous.
- Output SRAM layout, per matrix: nrows-K+1, ncols-K+1, then the output rows. Output bit c corresponds to window columns c..c+K-1. Bits >= ncols-K+1 are 0. Write address starts at 0 and increments per write.
- FSM states: IDLE, W_DIM, W_DATA, M_HDR, FILL, COMPUTE, WRITE, DONE.
  - IDLE: when dut_run=1, go to W_DIM. dut_busy=1 from the next cycle; dut_error clears.
  - W_DIM: latch K. If K is even, 0, or > KMAX: set dut_error, go to DONE.
  - W_DATA: latch 1 or 2 kernel words.
  - M_HDR: read nrows.
    - nrows == END_MARKER: go to DONE with no further writes.
    - Otherwise read ncols.
    - nrows < K, ncols < K, or ncols > DATA_W: set dut_error, go to DONE.
    - Otherwise write both output header words on consecutive cycles.
  - FILL: shift the first K rows into the K x DATA_W line buffer (oldest row = kernel row 0).
  - COMPUTE: one registered pipeline stage for the majority over all columns.
  - WRITE: one strobe per output row. If more input rows remain, read the next row, shift it in, and return to COMPUTE. Otherwise go to M_HDR at the next matrix base.
  - DONE: dut_busy=0 on the following cycle, then return to IDLE.
- dut_run asserted while busy: ignored.
- Reset mid-operation: immediate abort to IDLE with all outputs 0. No write strobe may occur in the reset-release cycle.
- Read addresses stay stable while their data is pending. Only one write strobe per cycle.

Decomposition:
- Package bnn_conv_pkg holds:
  - the state enum;
  - END_MARKER;
  - default widths;
  - function majority_thresh(K) = (K*K-1)/2.
- Sub-module bnn_row_majority, purely combinational:
  - inputs: line buffer, kernel bits, K, ncols;
  - output: the DATA_W-bit output row;
  - contains per-column XOR and popcount. The FSM/address logic stays in bnn_conv_engine.

Test Plan:
- K=3, weights 0x01FF, one 4x4 matrix of rows 0x000F, then 0x00FF -> writes 2, 2, 0x0003, 0x0003 at addrs 0-3; dut_busy falls after the 4th strobe.
- K=3, weights 0x0000, 3x16 matrix of rows 0xFFFF -> writes 1, 14, 0x0000 (all products negative).
- K=5, weights word1=0xFFFF, word2=0x01FF, 5x5 matrix of rows 0x001F -> writes 1, 1, 0x0001; confirms word2 is read.
- K=4 in weight word0 -> dut_error=1, no write strobes, dut_busy low within 3 cycles; next dut_run clears dut_error.
- Two back-to-back 3x3 matrices with K=3 -> headers and rows for both land contiguously at addrs 0-5.
- reset_b low during WRITE -> all outputs 0 immediately; a fresh dut_run reproduces the first scenario exactly.
